// File: rtl/serial_pad_pkg.sv
// Shared constants, count type and helpers for the serial pad emulator.
package serial_pad_pkg;

    localparam int FAMICOM_BITS = 8;
    localparam int SNES_BITS    = 16;
    localparam int MAX_BITS     = 32;
    localparam int MAX_CW       = $clog2(MAX_BITS + 1);

    // Wide enough for any legal frame length; channels truncate to their own width.
    typedef logic [MAX_CW-1:0] pad_count_t;

    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    // Saturating increment: holds once the frame length has been reached.
    function automatic pad_count_t sat_inc(input pad_count_t cnt, input pad_count_t limit);
        return (cnt < limit) ? pad_count_t'(cnt + 1'b1) : cnt;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser with registered rise/fall pulses.
// The level output is the edge detector's history flop, so level, rise and fall
// are all aligned to the same clk_sys cycle.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronise the asynchronous input, then register the edge pulses.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], raw};
            prev_q <= sync_q[STAGES-1];
            rise   <= ~prev_q & sync_q[STAGES-1];
            fall   <= prev_q & ~sync_q[STAGES-1];
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/serial_pad_emulator.sv
// CHANNELS independent 4021-style pad shift registers driven by shared latch/pulse.
module serial_pad_emulator
    import serial_pad_pkg::*;
#(
    parameter int   CHANNELS    = 2,
    parameter int   BITS        = FAMICOM_BITS,
    parameter logic FILL        = 1'b1,
    parameter int   SYNC_STAGES = 2,
    parameter bit   DATA_INVERT = 1'b0
) (
    input  logic                                    clk_sys,
    input  logic                                    reset_n,
    input  logic                                    latch,
    input  logic                                    pulse,
    input  logic [CHANNELS*BITS-1:0]                buttons,
    output logic [CHANNELS-1:0]                     data_out,
    output logic [CHANNELS*cnt_width(BITS)-1:0]     shift_count,
    output logic [CHANNELS-1:0]                     frame_done,
    output logic                                    latch_seen
);

    localparam int CW = cnt_width(BITS);

    logic latch_lvl;
    logic latch_fall;
    logic pulse_lvl;
    logic pulse_rise;
    logic pulse_fall;
    logic unused_edges;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw     (latch),
        .level   (latch_lvl),
        .rise    (latch_seen),
        .fall    (latch_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .raw     (pulse),
        .level   (pulse_lvl),
        .rise    (pulse_rise),
        .fall    (pulse_fall)
    );

    assign unused_edges = ^{latch_fall, pulse_rise, pulse_lvl};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [BITS-1:0] sreg_q;
        logic [BITS-1:0] shifted;
        logic [CW-1:0]   cnt_q;
        logic            done_q;
        pad_count_t      cnt_inc;

        if (BITS == 1) begin : g_single
            assign shifted = FILL;
        end else begin : g_multi
            assign shifted = {FILL, sreg_q[BITS-1:1]};
        end

        assign cnt_inc = sat_inc(pad_count_t'(cnt_q), pad_count_t'(BITS));

        // Transparent load while latched; otherwise shift on each synchronised pulse fall.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                sreg_q <= {BITS{FILL}};
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (latch_lvl) begin
                    sreg_q <= buttons[c*BITS +: BITS];
                    cnt_q  <= '0;
                end else if (pulse_fall) begin
                    sreg_q <= shifted;
                    cnt_q  <= CW'(cnt_inc);
                    done_q <= (cnt_q == CW'(BITS - 1));
                end
            end
        end

        assign data_out[c]             = sreg_q[0] ^ DATA_INVERT;
        assign shift_count[c*CW +: CW] = cnt_q;
        assign frame_done[c]           = done_q;
    end

endmodule

// File: tb/tb_serial_pad_emulator.sv
// Self-checking bench: four emulator configurations against a frame-level model.
module tb_serial_pad_emulator;
    import serial_pad_pkg::*;

    logic        clk_sys;
    logic        reset_n;
    logic        latch;
    logic        pulse;
    logic [15:0] btn_a;
    logic [15:0] btn_b;

    // d0: defaults, two channels
    logic [1:0] do0;
    logic [7:0] sc0;
    logic [1:0] fd0;
    logic       ls0;
    // d1: 16-bit, inverted data
    logic       do1;
    logic [4:0] sc1;
    logic       fd1;
    logic       ls1;
    // d2: three synchroniser stages
    logic       do2;
    logic [3:0] sc2;
    logic       fd2;
    logic       ls2;
    // d3: single-bit frame
    logic       do3;
    logic [0:0] sc3;
    logic       fd3;
    logic       ls3;

    serial_pad_emulator d0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .latch(latch), .pulse(pulse),
        .buttons({btn_b[7:0], btn_a[7:0]}), .data_out(do0), .shift_count(sc0),
        .frame_done(fd0), .latch_seen(ls0));

    serial_pad_emulator #(.CHANNELS(1), .BITS(SNES_BITS), .DATA_INVERT(1'b1)) d1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .latch(latch), .pulse(pulse),
        .buttons(btn_a), .data_out(do1), .shift_count(sc1),
        .frame_done(fd1), .latch_seen(ls1));

    serial_pad_emulator #(.CHANNELS(1), .SYNC_STAGES(3)) d2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .latch(latch), .pulse(pulse),
        .buttons(btn_b[7:0]), .data_out(do2), .shift_count(sc2),
        .frame_done(fd2), .latch_seen(ls2));

    serial_pad_emulator #(.CHANNELS(1), .BITS(1)) d3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .latch(latch), .pulse(pulse),
        .buttons(btn_a[0:0]), .data_out(do3), .shift_count(sc3),
        .frame_done(fd3), .latch_seen(ls3));

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lanes: 0,1 = d0 ch0/ch1, 2 = d1, 3 = d2, 4 = d3.
    localparam int NL = 5;
    int lane_b   [NL] = '{8, 8, 16, 8, 1};
    int lane_s   [NL] = '{2, 2, 2, 3, 2};
    int lane_inv [NL] = '{0, 0, 1, 0, 0};

    logic [15:0] m_word [NL];
    int          m_cnt  [NL];
    bit          m_done [NL];
    bit          m_seen [NL];
    bit          h_lat  [10];
    bit          h_pul  [10];
    int          done_cnt [NL] = '{0, 0, 0, 0, 0};

    function automatic logic [15:0] lane_word(input int l);
        case (l)
            0:       return {8'h00, btn_a[7:0]};
            1:       return {8'h00, btn_b[7:0]};
            2:       return btn_a;
            3:       return {8'h00, btn_b[7:0]};
            default: return {15'h0, btn_a[0]};
        endcase
    endfunction

    // Raw inputs are recorded once per edge; a lane sees them S+1 edges later.
    // The frame is a loaded word plus a read index; past the end it reads FILL (1).
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < NL; l++) begin
                m_word[l] = 16'hFFFF;
                m_cnt[l]  = 0;
                m_done[l] = 1'b0;
                m_seen[l] = 1'b0;
            end
            for (int j = 0; j < 10; j++) begin
                h_lat[j] = 1'b0;
                h_pul[j] = 1'b0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                int s;
                s = lane_s[l];
                m_seen[l] = h_lat[s-1] && !h_lat[s];
                m_done[l] = 1'b0;
                if (h_lat[s]) begin
                    m_word[l] = lane_word(l);
                    m_cnt[l]  = 0;
                end else if (h_pul[s+1] && !h_pul[s]) begin
                    m_done[l] = (m_cnt[l] == lane_b[l] - 1);
                    if (m_cnt[l] < lane_b[l]) m_cnt[l]++;
                end
            end
            for (int j = 9; j > 0; j--) begin
                h_lat[j] = h_lat[j-1];
                h_pul[j] = h_pul[j-1];
            end
            h_lat[0] = latch;
            h_pul[0] = pulse;
        end
    end

    function automatic int exp_data(input int l);
        logic b;
        b = (m_cnt[l] < lane_b[l]) ? m_word[l][m_cnt[l]] : 1'b1;
        return int'(b) ^ lane_inv[l];
    endfunction

    function automatic int act_data(input int l);
        case (l)
            0: return int'(do0[0]);
            1: return int'(do0[1]);
            2: return int'(do1);
            3: return int'(do2);
            default: return int'(do3);
        endcase
    endfunction

    function automatic int act_cnt(input int l);
        case (l)
            0: return int'(sc0[3:0]);
            1: return int'(sc0[7:4]);
            2: return int'(sc1);
            3: return int'(sc2);
            default: return int'(sc3);
        endcase
    endfunction

    function automatic int act_done(input int l);
        case (l)
            0: return int'(fd0[0]);
            1: return int'(fd0[1]);
            2: return int'(fd1);
            3: return int'(fd2);
            default: return int'(fd3);
        endcase
    endfunction

    function automatic int act_seen(input int l);
        case (l)
            0, 1: return int'(ls0);
            2:    return int'(ls1);
            3:    return int'(ls2);
            default: return int'(ls3);
        endcase
    endfunction

    // Compare every lane against the model on each falling edge.
    always @(negedge clk_sys) begin
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("lane%0d_data", l), act_data(l), exp_data(l));
            chk($sformatf("lane%0d_count", l), act_cnt(l), m_cnt[l]);
            chk($sformatf("lane%0d_done", l), act_done(l), int'(m_done[l]));
            if (l != 1) chk($sformatf("lane%0d_seen", l), act_seen(l), int'(m_seen[l]));
            if (act_done(l) != 0) done_cnt[l]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic fall_once();
        pulse = 1'b0;
        tick(3);
        pulse = 1'b1;
        tick(3);
    endtask

    task automatic do_latch();
        latch = 1'b1;
        tick(4);
        latch = 1'b0;
        tick(6);
    endtask

    bit seq0 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit seq1 [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    bit seq5a[8] = '{0, 1, 0, 1, 1, 0, 1, 0};

    initial begin
        int base0, base1, base2, base4;
        int n, lat0, lat2;
        logic prev0, prev2;

        reset_n = 1'b0;
        latch   = 1'b0;
        pulse   = 1'b1;
        btn_a   = 16'h0000;
        btn_b   = 16'h0000;
        tick(3);
        chk("reset_d0_data", int'(do0), 3);
        chk("reset_d1_data", int'(do1), 0);
        chk("reset_d0_count", int'(sc0), 0);
        chk("reset_latch_seen", int'(ls0), 0);
        #1 reset_n = 1'b1;
        tick(5);

        // Famicom frame on both d0 channels
        btn_a = 16'h00A5;
        btn_b = 16'h003C;
        do_latch();
        base0 = done_cnt[0];
        base1 = done_cnt[1];
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p1_ch0_bit%0d", i), int'(do0[0]), int'(seq0[i]));
            chk($sformatf("p1_ch1_bit%0d", i), int'(do0[1]), int'(seq1[i]));
            fall_once();
        end
        chk("p1_ch0_done", done_cnt[0] - base0, 1);
        chk("p1_ch1_done", done_cnt[1] - base1, 1);
        chk("p1_count", int'(sc0), 8'h88);
        chk("p1_fill", int'(do0), 3);
        for (int i = 0; i < 3; i++) fall_once();
        chk("p2_fill", int'(do0), 3);
        chk("p2_count_hold", int'(sc0), 8'h88);
        chk("p2_no_extra_done", done_cnt[0] - base0, 1);

        // Falls while latch is held: load wins
        btn_a = 16'h00FF;
        btn_b = 16'h00FF;
        latch = 1'b1;
        tick(4);
        for (int i = 0; i < 3; i++) fall_once();
        chk("p3_count_latched", int'(sc0), 0);
        chk("p3_data_latched", int'(do0), 3);
        latch = 1'b0;
        tick(6);
        chk("p3_count_after", int'(sc0), 0);
        fall_once();
        fall_once();
        chk("p3_data_ff", int'(do0), 3);
        chk("p3_count_two", int'(sc0), 8'h22);

        // 16-bit inverted frame; single-bit frame boundary on d3
        btn_a = 16'h8001;
        do_latch();
        chk("p4_bit0_inv", int'(do1), 0);
        base2 = done_cnt[2];
        base4 = done_cnt[4];
        fall_once();
        chk("p4_b1_count", int'(sc3), 1);
        chk("p4_b1_done", done_cnt[4] - base4, 1);
        for (int i = 1; i < 14; i++) fall_once();
        chk("p4_after14", int'(do1), 1);
        fall_once();
        chk("p4_after15", int'(do1), 0);
        chk("p4_no_done_yet", done_cnt[2] - base2, 0);
        fall_once();
        chk("p4_done16", done_cnt[2] - base2, 1);
        chk("p4_count16", int'(sc1), 16);

        // Latency from first sampling edge of a pulse fall
        btn_a = 16'h00A5;
        btn_b = 16'h0001;
        do_latch();
        prev0 = do0[0];
        prev2 = do2;
        lat0 = -1;
        lat2 = -1;
        n = 0;
        pulse = 1'b0;
        repeat (12) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (lat0 < 0 && do0[0] != prev0) lat0 = n - 1;
            if (lat2 < 0 && do2 != prev2) lat2 = n - 1;
        end
        chk("latency_s2", lat0, 3);
        chk("latency_s3", lat2, 4);
        @(negedge clk_sys);
        pulse = 1'b1;
        tick(6);

        // Asynchronous reset mid-frame, then a fresh frame
        btn_a = 16'h00A5;
        btn_b = 16'h003C;
        do_latch();
        for (int i = 0; i < 4; i++) fall_once();
        chk("p6_mid_count", int'(sc0), 8'h44);
        #2 reset_n = 1'b0;
        #1;
        chk("p6_rst_data0", int'(do0), 3);
        chk("p6_rst_data1", int'(do1), 0);
        chk("p6_rst_count", int'(sc0), 0);
        chk("p6_rst_done", int'(fd0), 0);
        tick(2);
        #1 reset_n = 1'b1;
        tick(4);
        btn_a = 16'h005A;
        do_latch();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p6_5a_bit%0d", i), int'(do0[0]), int'(seq5a[i]));
            fall_once();
        end

        // Randomised traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            latch = ($urandom_range(0, 11) == 0);
            pulse = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) btn_a = 16'($urandom);
            if ($urandom_range(0, 5) == 0) btn_b = 16'($urandom);
            tick($urandom_range(1, 3));
        end
        latch = 1'b0;
        pulse = 1'b1;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
